// File: rtl/load_store_unit_if.sv
//--------------------------------------------------------------------------
// Module      : load_store_unit_if
// Description : Single-outstanding req/ack data-memory bus between the
//               load/store unit (master) and data memory (slave).
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

interface lsu_mem_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memBe, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memBe, memWdata,
    output memRdata, memAck
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
//--------------------------------------------------------------------------
// Module      : load_store_unit
// Description : Byte/half/word load-store stage on a req/ack memory bus with
//               sign/zero load extension and misalignment detection.
//               Optional watchdog enabled by macro LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic        memWrite,
  input  wire logic [1:0]  memSize,
  input  wire logic        memSigned,
  input  wire logic [31:0] aluOut,
  input  wire logic [31:0] storeData,
  output logic             busy,
  output logic             done,
  output logic [31:0]      loadData,
  output logic             addrErr,
  output logic             busErr,
  lsu_mem_if.master        mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;

  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // Request decode; size 2'b11 behaves as a word.
  always_comb begin
    misaligned = ((memSize == 2'b01) && aluOut[0]) ||
                 (memSize[1] && (aluOut[1:0] != 2'b00));
    case (memSize)
      2'b00:   be_new = 4'b0001 << aluOut[1:0];
      2'b01:   be_new = aluOut[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
    case (memSize)
      2'b00:   wdata_new = {4{storeData[7:0]}};
      2'b01:   wdata_new = {2{storeData[15:0]}};
      default: wdata_new = storeData;
    endcase
  end

  always_comb begin
    byte_lane = mem.memRdata[{addr_lo_q, 3'b000} +: 8];
    half_lane = addr_lo_q[1] ? mem.memRdata[31:16] : mem.memRdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_ext = mem.memRdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    signed_d    = signed_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = (state_q == S_REQ) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          addr_err_d = misaligned;
          bus_err_d  = 1'b0;
          if (misaligned) begin
            // Rejected without touching the bus.
            state_d     = S_DONE;
            done_d      = 1'b1;
            load_data_d = '0;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = memWrite;
            mem_addr_d  = {aluOut[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            addr_lo_d   = aluOut[1:0];
            size_d      = memSize;
            signed_d    = memSigned;
          end
        end
      end
      S_REQ: begin
        if (mem.memAck) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          if (!mem_we_q) load_data_d = load_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (expired) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign loadData     = load_data_q;
  assign addrErr      = addr_err_q;
  assign busErr       = bus_err_q;
  assign mem.memReq   = mem_req_q;
  assign mem.memWe    = mem_we_q;
  assign mem.memAddr  = mem_addr_q;
  assign mem.memBe    = mem_be_q;
  assign mem.memWdata = mem_wdata_q;

endmodule

`default_nettype wire
